// File: rtl/dbl_reg_wr_arbiter.sv
// Round-robin write arbiter in front of a single-slot mailbox register: one write per slot
// occupancy, same-cycle status reads. Optional drain timeout under DBL_REG_WR_ARB_TIMEOUT_EN.
module dbl_reg_wr_arbiter #(
  parameter int NumWriters    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumWriters-1:0]            wr_req_i,
  input  logic [NumWriters-1:0]            wr_we_i,
  input  logic [NumWriters*DATA_WIDTH-1:0] wr_wdata_i,
  output logic [NumWriters-1:0]            wr_gnt_o,
  output logic [NumWriters-1:0]            wr_rvalid_o,
  output logic [DATA_WIDTH-1:0]            wr_rdata_o,
  output logic                             reg_req_o,
  output logic [DATA_WIDTH-1:0]            reg_wdata_o,
  input  logic                             reg_gnt_i,
  input  logic                             rd_done_i,
  output logic                             full_o,
  output logic [$clog2(NumWriters)-1:0]    owner_o,
  output logic                             timeout_o
);

  localparam int IdxW = $clog2(NumWriters);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  if (NumWriters < 2 || TimeoutCycles < 2) begin : g_param_check
    $error("dbl_reg_wr_arbiter: NumWriters and TimeoutCycles must be at least 2");
  end

  logic [0:0]            state;
  logic [IdxW-1:0]       rr_ptr;
  logic [NumWriters-1:0] eligible;
  logic [NumWriters-1:0] read_gnt;
  logic [NumWriters-1:0] write_gnt;
  logic [IdxW:0]         cand;
  logic [IdxW-1:0]       win_idx;
  logic [IdxW-1:0]       next_ptr;
  logic                  win_valid;
  logic                  can_issue;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] win_data;
  logic [DATA_WIDTH-1:0] status;

  assign eligible  = wr_req_i & wr_we_i;
  assign read_gnt  = wr_req_i & ~wr_we_i;
  assign full_o    = (state == ST_HELD);
  assign can_issue = (state == ST_EMPTY) || rd_done_i;

  // Search upward from rr_ptr; cand never exceeds 2*NumWriters-2, so one subtraction wraps it.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumWriters; i++) begin
      cand = {1'b0, rr_ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumWriters)) cand = cand - (IdxW+1)'(NumWriters);
      if (!win_valid && eligible[cand[IdxW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    win_data  = '0;
    write_gnt = '0;
    for (int k = 0; k < NumWriters; k++) begin
      if (win_idx == IdxW'(k)) win_data = wr_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      write_gnt[k] = wr_fire && (win_idx == IdxW'(k));
    end
  end

  assign next_ptr = (win_idx == IdxW'(NumWriters - 1)) ? '0 : win_idx + 1'b1;

  // Combinational outputs are forced low while reset is asserted.
  assign reg_req_o   = rst_ni && can_issue && win_valid;
  assign reg_wdata_o = reg_req_o ? win_data : '0;
  assign wr_fire     = reg_req_o && reg_gnt_i;
  assign wr_gnt_o    = rst_ni ? (read_gnt | write_gnt) : '0;

  always_comb begin
    status            = '0;
    status[0]         = full_o;
    status[1]         = timeout_o;
    status[8 +: IdxW] = owner_o;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_EMPTY;
      rr_ptr      <= '0;
      owner_o     <= '0;
      wr_rvalid_o <= '0;
      wr_rdata_o  <= '0;
    end else begin
      wr_rvalid_o <= wr_gnt_o;
      wr_rdata_o  <= (|wr_gnt_o) ? status : '0;
      if (wr_fire) begin
        state   <= ST_HELD;
        owner_o <= win_idx;
        rr_ptr  <= next_ptr;
      end else if (rd_done_i) begin
        state <= ST_EMPTY;
      end
    end
  end

`ifdef DBL_REG_WR_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] to_cnt;

  // Counter saturates at TimeoutCycles; the flag follows one cycle later and holds until rd_done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (rd_done_i || wr_fire) begin
        to_cnt <= '0;
      end else if (full_o && to_cnt != CntW'(TimeoutCycles)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (rd_done_i) begin
        timeout_o <= 1'b0;
      end else if (to_cnt == CntW'(TimeoutCycles)) begin
        timeout_o <= 1'b1;
      end
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dbl_reg_wr_arbiter.sv
// Directed bench for dbl_reg_wr_arbiter: reset, single write, stall/drain, status read,
// round-robin order, timeout flag (both builds) and mid-operation reset.
module tb_dbl_reg_wr_arbiter;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

`ifdef DBL_REG_WR_ARB_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [NW-1:0]    wr_req_i = '0;
  logic [NW-1:0]    wr_we_i = '0;
  logic [NW*DW-1:0] wr_wdata_i = '0;
  logic [NW-1:0]    wr_gnt_o;
  logic [NW-1:0]    wr_rvalid_o;
  logic [DW-1:0]    wr_rdata_o;
  logic             reg_req_o;
  logic [DW-1:0]    reg_wdata_o;
  logic             reg_gnt_i = 1'b0;
  logic             rd_done_i = 1'b0;
  logic             full_o;
  logic [1:0]       owner_o;
  logic             timeout_o;

  int n_total = 0;
  int n_bad   = 0;

  dbl_reg_wr_arbiter #(
    .NumWriters   (NW),
    .DATA_WIDTH   (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_req_i   (wr_req_i),
    .wr_we_i    (wr_we_i),
    .wr_wdata_i (wr_wdata_i),
    .wr_gnt_o   (wr_gnt_o),
    .wr_rvalid_o(wr_rvalid_o),
    .wr_rdata_o (wr_rdata_o),
    .reg_req_o  (reg_req_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_gnt_i  (reg_gnt_i),
    .rd_done_i  (rd_done_i),
    .full_o     (full_o),
    .owner_o    (owner_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset held with inputs toggling: every output low.
    reg_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_req_i   = 4'b1111;
      wr_we_i    = (i % 2 == 0) ? 4'b0101 : 4'b1111;
      wr_wdata_i = {4{32'hA5A5_0000 + 32'(i)}};
      rd_done_i  = (i % 2 == 1);
      #1;
      check("rst_gnt", 64'(wr_gnt_o), 64'h0);
      check("rst_req", 64'(reg_req_o), 64'h0);
      check("rst_wdata", 64'(reg_wdata_o), 64'h0);
      check("rst_rvalid", 64'(wr_rvalid_o), 64'h0);
      check("rst_rdata", 64'(wr_rdata_o), 64'h0);
      check("rst_full_owner_to", 64'({full_o, owner_o, timeout_o}), 64'h0);
      tick();
    end
    wr_req_i   = '0;
    wr_we_i    = '0;
    wr_wdata_i = '0;
    rd_done_i  = 1'b0;
    rst_ni     = 1'b1;
    tick();
    check("post_rst_full", 64'(full_o), 64'h0);
    check("post_rst_owner", 64'(owner_o), 64'h0);

    // Single write from producer 2.
    wr_req_i = 4'b0100;
    wr_we_i  = 4'b0100;
    wr_wdata_i[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    check("w2_gnt", 64'(wr_gnt_o), 64'h4);
    check("w2_req", 64'(reg_req_o), 64'h1);
    check("w2_wdata", 64'(reg_wdata_o), 64'hDEAD_BEEF);
    tick();
    wr_req_i = '0;
    wr_we_i  = '0;
    check("w2_rvalid", 64'(wr_rvalid_o), 64'h4);
    check("w2_rdata", 64'(wr_rdata_o), 64'h0);
    check("w2_full", 64'(full_o), 64'h1);
    check("w2_owner", 64'(owner_o), 64'h2);

    // Stall while HELD, then grant in the rd_done cycle.
    wr_req_i = 4'b0001;
    wr_we_i  = 4'b0001;
    wr_wdata_i[0 +: DW] = 32'h1111_1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_gnt", 64'(wr_gnt_o), 64'h0);
      check("stall_req", 64'(reg_req_o), 64'h0);
      tick();
    end
    rd_done_i = 1'b1;
    #1;
    check("drain_gnt", 64'(wr_gnt_o), 64'h1);
    check("drain_wdata", 64'(reg_wdata_o), 64'h1111_1111);
    tick();
    rd_done_i = 1'b0;
    wr_req_i  = '0;
    wr_we_i   = '0;
    check("drain_full", 64'(full_o), 64'h1);
    check("drain_owner", 64'(owner_o), 64'h0);
    check("drain_rvalid", 64'(wr_rvalid_o), 64'h1);

    // Drain with no requester empties the slot; owner is kept.
    rd_done_i = 1'b1;
    tick();
    rd_done_i = 1'b0;
    check("empty_full", 64'(full_o), 64'h0);
    check("empty_owner", 64'(owner_o), 64'h0);
    // Spurious rd_done while EMPTY.
    rd_done_i = 1'b1;
    tick();
    rd_done_i = 1'b0;
    check("spurious_full", 64'(full_o), 64'h0);

    // Producer 3 writes (pointer is 1, only 3 eligible).
    wr_req_i = 4'b1000;
    wr_we_i  = 4'b1000;
    wr_wdata_i[3*DW +: DW] = 32'h3333_3333;
    #1;
    check("w3_gnt", 64'(wr_gnt_o), 64'h8);
    tick();
    wr_req_i = '0;
    wr_we_i  = '0;
    check("w3_owner", 64'(owner_o), 64'h3);

    // Status read by producer 1 while HELD with owner 3.
    wr_req_i = 4'b0010;
    wr_we_i  = 4'b0000;
    #1;
    check("sr_gnt", 64'(wr_gnt_o), 64'h2);
    check("sr_req", 64'(reg_req_o), 64'h0);
    tick();
    wr_req_i = '0;
    check("sr_rvalid", 64'(wr_rvalid_o), 64'h2);
    check("sr_rdata", 64'(wr_rdata_o), 64'h301);

    // Round-robin: all write continuously, rd_done every 3rd cycle; pointer starts at 0.
    wr_req_i = 4'b1111;
    wr_we_i  = 4'b1111;
    for (int k = 0; k < NW; k++) wr_wdata_i[k*DW +: DW] = 32'hA000_0000 + 32'(k);
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < 2; j++) begin
        #1;
        check("rr_idle_gnt", 64'(wr_gnt_o), 64'h0);
        tick();
      end
      rd_done_i = 1'b1;
      #1;
      check("rr_gnt", 64'(wr_gnt_o), 64'(4'b0001 << (g % 4)));
      check("rr_wdata", 64'(reg_wdata_o), 64'(32'hA000_0000 + 32'(g % 4)));
      tick();
      rd_done_i = 1'b0;
    end
    wr_req_i = '0;
    wr_we_i  = '0;
    check("rr_owner", 64'(owner_o), 64'h1);

    // Timeout: slot entered HELD at the last edge; flag after 9 cycles in the enabled build.
    for (int i = 0; i < 7; i++) tick();
    tick();
    check("to_before", 64'(timeout_o), 64'h0);
    tick();
    check("to_after9", 64'(timeout_o), 64'(TO_EN));
    for (int i = 0; i < 3; i++) tick();
    check("to_sticky", 64'(timeout_o), 64'(TO_EN));
    rd_done_i = 1'b1;
    tick();
    rd_done_i = 1'b0;
    check("to_clear", 64'(timeout_o), 64'h0);
    check("to_full", 64'(full_o), 64'h0);

    // Asynchronous reset with a response pending.
    wr_req_i = 4'b0001;
    wr_we_i  = 4'b0001;
    tick();
    wr_req_i = '0;
    wr_we_i  = '0;
    check("ar_rvalid_pre", 64'(wr_rvalid_o), 64'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("ar_rvalid", 64'(wr_rvalid_o), 64'h0);
    check("ar_full", 64'(full_o), 64'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("ar_post_full", 64'(full_o), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
